// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes, FSM states and default sizes shared by the multiply/divide unit.
package muldiv_pkg;
    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;
    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_e;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration, shift-add multiply or restoring shift-subtract divide.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [2*WIDTH-1:0]   opa_i,
    input  logic [WIDTH-1:0]     opb_i,
    output logic [2*WIDTH-1:0]   acc_o,
    output logic [2*WIDTH-1:0]   opa_o,
    output logic [WIDTH-1:0]     opb_o
);
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;
    // Divide keeps {remainder, quotient} in acc; the dividend is shifted out of opa's low half.
    always_comb begin
        rem_sh = {acc_i[2*WIDTH-1:WIDTH], opa_i[WIDTH-1]};
        diff   = rem_sh - {1'b0, opb_i};
        opa_o  = opa_i << 1;
        opb_o  = is_div ? opb_i : opb_i >> 1;
        acc_o  = is_div ? {diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0], acc_i[WIDTH-2:0], ~diff[WIDTH]}
                        : acc_i + (opb_i[0] ? opa_i : '0);
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO and MTHI/MTLO/MF read port.
// MULDIV_EARLY_OUT_EN: finish a multiply as soon as the remaining multiplier bits are zero.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mf_req,
    input  logic             mf_sel,
    output logic [WIDTH-1:0] mf_data,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, opa_q, opa_d, acc_s, opa_s, prod;
    logic [WIDTH-1:0]   opb_q, opb_d, opb_s, rs_q, rs_d, hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   a_abs, b_abs, quo, rem;
    logic               div_q, div_d, neg_q, neg_d, sa_q, sa_d, done_q, done_d;
    logic               signed_op, sa, sb, last;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (div_q),
        .acc_i  (acc_q),
        .opa_i  (opa_q),
        .opb_i  (opb_q),
        .acc_o  (acc_s),
        .opa_o  (opa_s),
        .opb_o  (opb_s)
    );

    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign sa        = signed_op & rs_data[WIDTH-1];
    assign sb        = signed_op & rt_data[WIDTH-1];
    assign a_abs     = sa ? -rs_data : rs_data;
    assign b_abs     = sb ? -rt_data : rt_data;
    assign prod      = neg_q ? -acc_q : acc_q;
    assign quo       = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem       = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`ifdef MULDIV_EARLY_OUT_EN
    assign last      = (cnt_q == CNT_W'(WIDTH - 1)) || (!div_q && opb_s == '0);
`else
    assign last      = cnt_q == CNT_W'(WIDTH - 1);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        rs_d    = rs_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        div_d   = div_q;
        neg_d   = neg_q;
        sa_d    = sa_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && op < OP_MTHI) begin
                    state_d = S_CALC;
                    cnt_d   = '0;
                    acc_d   = '0;
                    opa_d   = {{WIDTH{1'b0}}, a_abs};
                    opb_d   = b_abs;
                    rs_d    = rs_data;
                    div_d   = op[1];
                    neg_d   = sa ^ sb;
                    sa_d    = sa;
                end
                hi_d = (start && op == OP_MTHI) ? rs_data : hi_q;
                lo_d = (start && op == OP_MTLO) ? rs_data : lo_q;
            end
            S_CALC: begin
                acc_d   = acc_s;
                opa_d   = opa_s;
                opb_d   = opb_s;
                cnt_d   = cnt_q + 1'b1;
                state_d = last ? S_FIX : S_CALC;
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                // Overflow (MIN / -1) needs no special case: |MIN| negated wraps back to MIN.
                hi_d    = !div_q ? prod[2*WIDTH-1:WIDTH] : (opb_q == '0) ? rs_q : rem;
                lo_d    = !div_q ? prod[WIDTH-1:0] : (opb_q == '0) ? '1 : quo;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            rs_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            sa_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            rs_q    <= rs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            sa_q    <= sa_d;
            done_q  <= done_d;
        end
    end

    assign busy    = state_q != S_IDLE;
    assign done    = done_q;
    assign stall   = busy & (mf_req | start);
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign mf_data = mf_sel ? hi_q : lo_q;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core.
- Sits in the EX stage, alongside the ALU.
- Executes MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Supplies MFHI/MFLO data on mf_data, which the writeback mux routes to the register-file write-data port (RdData).
- Raises stall so the pipeline holds an instruction that needs HI/LO while an operation is in flight.

Parameters:
- WIDTH, 32, operand/HI/LO width in bits.
- CNT_W, 6, iteration-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to execute op this cycle.
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are no-ops.
- rs_data  input  WIDTH  operand A (dividend / multiplicand / MT source).
- rt_data  input  WIDTH  operand B (divisor / multiplier).
- mf_req  input  1  current instruction is MFHI/MFLO.
- mf_sel  input  1  1 = read HI, 0 = read LO.
- mf_data  output  WIDTH  combinational: mf_sel ? HI : LO.
- busy  output  1  high while state is not IDLE.
- done  output  1  one-cycle pulse when a mul/div result is committed.
- stall  output  1  busy & (mf_req | start).
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset is asynchronous: state=IDLE, HI=0, LO=0, counter=0, done=0, busy=0. Reset asserted mid-operation discards the operation.
- FSM states: IDLE, CALC, FIX.
- IDLE, start with op 0-3 at edge E0:
  - Latch abs(rs)/abs(rt) for signed ops, raw values for unsigned ops.
  - Latch sign flags.
  - Clear the accumulator and counter; go to CALC.
- IDLE, start with op 4/5: write rs_data to HI or LO at that edge. No busy, no done. Other state unchanged.
- CALC: one radix-2 step per edge, WIDTH steps (E1..E32 for WIDTH=32).
  - Multiply: shift-add into a 2*WIDTH product.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - After step WIDTH, go to FIX.
- FIX (E33):
  - Apply sign correction and write HI/LO.
  - done=1 for the following cycle.
  - Go to IDLE.
- Latency: busy is high from after E0 through E33. HI/LO are new from E33. The earliest accepted next start is at E34.
- Sign rules:
  - MULT: negate the 2*WIDTH product if the operand signs differ.
  - DIV: the quotient is negated if signs differ. The remainder takes the dividend's sign.
- Divide by zero (both signed and unsigned): LO=all ones, HI=rs_data unmodified.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
- start while busy: ignored, no queueing. stall forces upstream to hold the instruction and re-present it.
- mf_req while busy: stall=1, and mf_data shows the old HI/LO, which must not be used. In IDLE, including the done cycle, mf_data reflects the committed result.
- Unused op codes 6/7: no effect.

Optional Feature:
- MULDIV_EARLY_OUT_EN
- When defined:
  - In multiply CALC, if the remaining unshifted multiplier bits are all zero, go to FIX on the next edge. Multiply latency is then data-dependent, with a minimum of 2 cycles busy.
  - Division is unchanged.
- When undefined: fixed WIDTH+2 edge latency for all mul/div ops.

Decomposition:
- Shared package muldiv_pkg holds:
  - the op encodings (OP_MULT .. OP_MTLO);
  - the FSM state encoding;
  - default WIDTH/CNT_W constants.
- One sub-module is natural: muldiv_step, a combinational single-iteration datapath (shift-add or shift-subtract selected by an is_div input). The top level owns the FSM, counter, operand/sign registers, and HI/LO.

Test Plan:
- MULTU: rs=0xFFFFFFFF, rt=0x2 → after E33, HI=0x00000001, LO=0xFFFFFFFE; done pulses exactly once; busy high for 33 cycles.
- MULT: rs=0xFFFFFFFD (-3), rt=0x7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
- DIV: rs=0xFFFFFFF9 (-7), rt=0x2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU: rs=100, rt=0 → LO=0xFFFFFFFF, HI=100.
  - DIV: rs=0x80000000, rt=0xFFFFFFFF → LO=0x80000000, HI=0.
- Issue DIVU, then mf_req=1 at E5 → stall=1 until E33. After E33, mf_sel=0 returns the quotient on mf_data.
  - A second start at E10 is ignored and HI/LO reflect only the first op.
- MTHI rs=0x1234 in IDLE → HI=0x1234 next cycle, busy stays 0.
  - Then start MULT and assert rst at E12 → immediately busy=0, HI=LO=0, done never pulses.
- With MULDIV_EARLY_OUT_EN: MULTU rs=5, rt=1 → HI=0, LO=5, busy deasserts after no more than 3 edges.
  - Without the macro, the same op takes 33 busy cycles.
